// File: rtl/shift_seq.sv
`default_nettype none
// ============================================================================
//  Module   : shift_seq
//  Purpose  : Multi-cycle sequential shifter. An accepted start latches the
//             operand, opcode and step count, then applies one 1-bit shift
//             per clock until the count is exhausted, pulsing done once.
//  Ports    : clk       - clock, all state updates on the rising edge
//             reset     - synchronous active-high reset
//             start     - request a new operation (ignored while busy)
//             shift_op  - 00 hold, 01 left, 10 logical right, 11 arith right
//             amount    - number of 1-bit steps (0..WIDTH-1)
//             shift_in  - operand
//             shift_out - result register
//             busy      - high in SHIFT and DONE
//             done      - one-cycle pulse marking a valid result
//  Revision : 1.0 - initial release
// ============================================================================
module shift_seq #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       shift_op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] shift_in,
  output logic [WIDTH-1:0] shift_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_SLL  = 2'b01;
  localparam logic [1:0] OP_SRL  = 2'b10;
  localparam logic [1:0] OP_SRA  = 2'b11;

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [1:0]       op_q;
  logic [AMT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  // One 1-bit step of the latched operation. Plain bit selects are used so
  // that X/Z in the operand travels with the shifted bits unmasked.
  always_comb begin
    shift_d = shift_q;
    case (op_q)
      OP_NONE: shift_d = shift_q;
      OP_SLL:  shift_d = {shift_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_d = {1'b0, shift_q[WIDTH-1:1]};
      OP_SRA:  shift_d = {shift_q[WIDTH-1], shift_q[WIDTH-1:1]};
      default: shift_d = shift_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      op_q    <= OP_NONE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            shift_q <= shift_in;
            op_q    <= shift_op;
            cnt_q   <= amount;
            busy_q  <= 1'b1;
            // A zero-step request skips SHIFT and reports on the next cycle.
            if (amount != '0) begin
              state_q <= S_SHIFT;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          shift_q <= shift_d;
          cnt_q   <= cnt_q - AMT_W'(1);
          // The final step is applied on the same edge that moves to DONE.
          if (cnt_q == AMT_W'(1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign shift_out = shift_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_seq
//  Purpose  : Directed self-checking bench for shift_seq. Cycle k is the k-th
//             cycle after the edge that sampled start; outputs are sampled on
//             the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_seq;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;
  localparam int MAX_CYC = 40;

  logic             clk;
  logic             reset;
  logic             start;
  logic [1:0]       shift_op;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] shift_in;
  logic [WIDTH-1:0] shift_out;
  logic             busy;
  logic             done;

  int n_tests;
  int n_fail;
  logic [WIDTH-1:0] last_res;

  shift_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .shift_op  (shift_op),
    .amount    (amount),
    .shift_in  (shift_in),
    .shift_out (shift_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts one operation from IDLE and follows it to done, checking busy in
  // every cycle, the cycle in which done appears and the final result.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [AMT_W-1:0] amt,
                        input logic [WIDTH-1:0] din, input logic [WIDTH-1:0] exp_out,
                        input int exp_cyc);
    int cyc;
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_hold"}, 32'(shift_out), 32'(last_res));
    start    = 1'b1;
    shift_op = op;
    amount   = amt;
    shift_in = din;
    @(negedge clk);
    start    = 1'b0;
    shift_in = 16'hDEAD;
    shift_op = 2'b00;
    amount   = '0;
    cyc = 1;
    while (!done && cyc < MAX_CYC) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_cyc"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    check({tag, "_result"}, 32'(shift_out), 32'(exp_out));
    last_res = exp_out;
  endtask

  initial begin
    int cyc;
    int seen_done;
    n_tests  = 0;
    n_fail   = 0;
    last_res = '0;
    reset    = 1'b1;
    start    = 1'b0;
    shift_op = 2'b00;
    amount   = '0;
    shift_in = '0;
    repeat (2) @(negedge clk);
    check("rst_out",  32'(shift_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    run_op("sll1",   2'b01, 4'd1,  16'hF0CF, 16'hE19E, 2);
    run_op("sra4",   2'b11, 4'd4,  16'hF0CF, 16'hFF0C, 5);
    run_op("srl4",   2'b10, 4'd4,  16'hF0CF, 16'h0F0C, 5);
    run_op("nop5",   2'b00, 4'd5,  16'hF0CF, 16'hF0CF, 6);
    run_op("sll15",  2'b01, 4'd15, 16'h0001, 16'h8000, 16);
    run_op("amt0",   2'b11, 4'd0,  16'h8421, 16'h8421, 1);
    run_op("sra_pos",2'b11, 4'd3,  16'h7F00, 16'h0FE0, 4);

    // Start while busy must be ignored.
    @(negedge clk);
    start = 1'b1; shift_op = 2'b10; amount = 4'd8; shift_in = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    seen_done = 0;
    while (!done && cyc < MAX_CYC) begin
      if (cyc == 3) begin
        start = 1'b1; shift_in = 16'h1234; shift_op = 2'b01; amount = 4'd1;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    check("ign_done_cyc", 32'(cyc), 32'd9);
    check("ign_result", 32'(shift_out), 32'h00FF);
    last_res = 16'h00FF;

    // Reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; shift_op = 2'b01; amount = 4'd10; shift_in = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst2_out",  32'(shift_out), 32'd0);
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_done", 32'(done), 32'd0);
    reset = 1'b0;
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    check("rst2_no_done", 32'(seen_done), 32'd0);
    last_res = '0;
    run_op("post_rst", 2'b01, 4'd2, 16'h0003, 16'h000C, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 Parameter: WIDTH, 16, datapath width in bits.
REQ-002 Parameter: AMT_W, 4, width of the shift-amount port; the legal amount range is 0..WIDTH-1.
REQ-003 Port: clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port: start  input  1  request to begin a shift operation.
REQ-006 Port: shift_op  input  2  operation code: 00 no shift, 01 left shift, 10 logical right shift, 11 arithmetic right shift.
REQ-007 Port: amount  input  AMT_W  number of single-bit shift steps to perform.
REQ-008 Port: shift_in  input  WIDTH  operand.
REQ-009 Port: shift_out  output  WIDTH  result register.
REQ-010 Port: busy  output  1  high while an operation is in progress (state not IDLE).
REQ-011 Port: done  output  1  one-cycle pulse marking a valid result.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 In IDLE with start=1, on the clock edge the block SHALL latch shift_in into shift_out, latch shift_op, and load the step counter with amount.
REQ-014 From IDLE with start=1, the FSM SHALL go to SHIFT if amount != 0 and to DONE if amount == 0.
REQ-015 In SHIFT, each edge SHALL apply one 1-bit step to shift_out and decrement the counter.
- 00: value held.
- 01: {x[WIDTH-2:0],0}.
- 10: {0,x[WIDTH-1:1]}.
- 11: {x[WIDTH-1],x[WIDTH-1:1]}.
REQ-016 When the counter equals 1 in SHIFT, the FSM SHALL go to DONE on that edge, after the final step has been applied.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-018 Latency: done SHALL be high during the (amount+1)th cycle after the cycle in which start was sampled; amount=0 gives 1 cycle and amount=15 gives 16 cycles.
REQ-019 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-020 start SHALL be ignored while busy=1; shift_in, shift_op and amount SHALL be sampled only on the accepting edge.
REQ-021 shift_out SHALL hold the result from DONE through IDLE until the next accepted start.
REQ-022 A start asserted in the IDLE cycle immediately after DONE SHALL be accepted, giving back-to-back operations with one idle cycle between them.
REQ-023 The result SHALL equal the combinational single-shift result applied amount times; left and logical shifts fill with 0, arithmetic shifts replicate the MSB.
REQ-024 If shift_in contains X/Z, the block SHALL propagate X/Z through the shifted bits with no internal masking; op 00 SHALL return shift_in bit-exact.

Reset
REQ-025 reset=1 SHALL force, on the next edge: state=IDLE, shift_out=0, busy=0, done=0, counter=0.
REQ-026 reset SHALL take priority over start and over any in-progress operation; an interrupted operation SHALL produce no done pulse.
REQ-027 After reset is deasserted, the first start SHALL be accepted on the first edge at which it is sampled high.

Verification
REQ-028 The bench SHALL drive start with shift_in=0xF0CF, op=01, amount=1 -> done in cycle 2, shift_out=0xE19E.
REQ-029 The bench SHALL drive shift_in=0xF0CF with amount=4, op=11 and then op=10 -> shift_out=0xFF0C and 0x0F0C respectively, done in cycle 5 each.
REQ-030 The bench SHALL drive shift_in=0xF0CF, op=00, amount=5 -> shift_out=0xF0CF, done in cycle 6, busy high for cycles 1-6.
REQ-031 The bench SHALL drive shift_in=0x0001, op=01, amount=15 -> shift_out=0x8000, done in cycle 16.
REQ-032 The bench SHALL start op=10, amount=8 on 0xFFFF, then pulse start with shift_in=0x1234 in cycle 3 -> the second start is ignored and shift_out=0x00FF.
REQ-033 The bench SHALL start op=01, amount=10, then assert reset in cycle 4 -> next edge shift_out=0, busy=0, no done pulse; a subsequent start on 0x0003, op=01, amount=2 gives 0x000C.
